// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and the data memory (slave).
// The request side is held stable from acceptance until ack; rdata is valid only with ack.
interface mem_access_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            ack;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: decodes loads/stores, runs a two-state bus FSM,
// formats store lanes, extends load data and registers the register-file writeback.
module mem_access #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [11:0]       operation,
    input  logic [XLEN-1:0]   resultALU,
    input  logic [4:0]        address_rd,
    input  logic [XLEN-1:0]   content_rs2,
    input  logic              wb_en_in,
    output logic              stall,
    mem_access_if.master      dmem,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [XLEN-1:0]   wb_data,
    output logic              mem_fault
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t state, next_state;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [1:0]      lo;
    logic            is_load, is_store, is_mem;
    logic            illegal, misaligned, legal_mem, fault;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;

    logic [4:0]      rd_q;
    logic [2:0]      f3_q;
    logic [1:0]      lo_q;
    logic            ld_q;
    logic [XLEN-1:0] shifted, ld_data;
    logic            unused_bits;

    assign opcode      = operation[6:0];
    assign funct3      = operation[9:7];
    assign lo          = resultALU[1:0];
    assign unused_bits = ^operation[11:10];

    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);
    assign is_mem   = is_load | is_store;

    // funct3[1:0] encodes access size for both loads and stores (00 byte, 01 half, 10 word)
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        if (is_load)
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        else if (is_store)
            illegal = funct3[2] || (funct3 == 3'b011);
        if (funct3[1:0] == 2'b01)
            misaligned = lo[0];
        else if (funct3[1:0] == 2'b10)
            misaligned = (lo != 2'b00);
    end

    assign legal_mem = is_mem && !illegal && !misaligned;
    assign fault     = valid_in && is_mem && (illegal || misaligned);

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = content_rs2;
        if (is_store) begin
            case (funct3)
                3'b000: begin
                    st_be    = 4'b0001 << lo;
                    st_wdata = {4{content_rs2[7:0]}};
                end
                3'b001: begin
                    st_be    = 4'b0011 << lo;
                    st_wdata = {2{content_rs2[15:0]}};
                end
                default: begin
                    st_be    = 4'b1111;
                    st_wdata = content_rs2;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    // stall is forced low during reset so upstream never waits on an aborted access
    always_comb begin
        next_state = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in && legal_mem) begin
                    next_state = ACCESS;
                    stall      = reset;
                end
            end
            ACCESS: begin
                if (dmem.ack)
                    next_state = IDLE;
                else
                    stall = reset;
            end
            default: next_state = IDLE;
        endcase
    end

    assign shifted = dmem.rdata >> {lo_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'b0, shifted[7:0]};
            3'b101:  ld_data = {16'b0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    // Bus request and writeback registers; wb_valid and mem_fault default low so they pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.be    <= 4'b0000;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= '0;
            mem_fault  <= 1'b0;
            rd_q       <= 5'd0;
            f3_q       <= 3'b000;
            lo_q       <= 2'b00;
            ld_q       <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_fault <= 1'b0;
            if (state == IDLE) begin
                if (valid_in && legal_mem) begin
                    dmem.req   <= 1'b1;
                    dmem.we    <= is_store;
                    dmem.be    <= st_be;
                    dmem.addr  <= {resultALU[XLEN-1:2], 2'b00};
                    dmem.wdata <= st_wdata;
                    rd_q       <= address_rd;
                    f3_q       <= funct3;
                    lo_q       <= lo;
                    ld_q       <= is_load;
                end else if (fault) begin
                    mem_fault <= 1'b1;
                end else if (valid_in && !is_mem && wb_en_in && address_rd != 5'd0) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= address_rd;
                    wb_data  <= resultALU;
                end
            end else if (dmem.ack) begin
                dmem.req <= 1'b0;
                dmem.we  <= 1'b0;
                if (ld_q && rd_q != 5'd0) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= ld_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: loads with extension, stores with lane formatting,
// faults, ALU writeback, rd=0 suppression, stray ack and reset during an access.
module tb_mem_access;

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [6:0]  OP_ALU   = 7'b0110011;
    localparam logic [11:0] LB  = {2'b00, 3'b000, OP_LOAD};
    localparam logic [11:0] LH  = {2'b00, 3'b001, OP_LOAD};
    localparam logic [11:0] LW  = {2'b00, 3'b010, OP_LOAD};
    localparam logic [11:0] LBU = {2'b00, 3'b100, OP_LOAD};
    localparam logic [11:0] LD3 = {2'b00, 3'b011, OP_LOAD};
    localparam logic [11:0] SB  = {2'b00, 3'b000, OP_STORE};
    localparam logic [11:0] SH  = {2'b00, 3'b001, OP_STORE};
    localparam logic [11:0] ADD = {2'b00, 3'b000, OP_ALU};

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [11:0] operation;
    logic [31:0] resultALU;
    logic [4:0]  address_rd;
    logic [31:0] content_rs2;
    logic        wb_en_in;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_fault;

    int checks   = 0;
    int failures = 0;

    mem_access_if #(.XLEN(32)) dmem ();

    mem_access #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .operation   (operation),
        .resultALU   (resultALU),
        .address_rd  (address_rd),
        .content_rs2 (content_rs2),
        .wb_en_in    (wb_en_in),
        .stall       (stall),
        .dmem        (dmem),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .mem_fault   (mem_fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] op, input logic [31:0] alu, input logic [4:0] rd,
                                 input logic [31:0] rs2, input logic wben);
        valid_in    = 1'b1;
        operation   = op;
        resultALU   = alu;
        address_rd  = rd;
        content_rs2 = rs2;
        wb_en_in    = wben;
    endtask

    // Single-wait-free load: issue, one ACCESS cycle with ack, then check the writeback
    task automatic quickLoad(input string tag, input logic [11:0] op, input logic [31:0] addr,
                             input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] expected);
        applyStimulus(op, addr, rd, 32'h0, 1'b0);
        @(negedge clk);
        dmem.ack   = 1'b1;
        dmem.rdata = rdata;
        valid_in   = 1'b0;
        @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        checkOutput({tag, "_rd"}, 32'(wb_rd), 32'(rd));
        checkOutput({tag, "_data"}, wb_data, expected);
    endtask

    initial begin
        reset = 1'b0;
        dmem.ack = 1'b0;
        dmem.rdata = 32'h0;
        applyStimulus(LW, 32'h100, 5'd5, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_req", 32'(dmem.req), 32'd0);
        checkOutput("rst_be", 32'(dmem.be), 32'd0);
        checkOutput("rst_addr", dmem.addr, 32'd0);
        checkOutput("rst_wbv", 32'(wb_valid), 32'd0);
        checkOutput("rst_fault", 32'(mem_fault), 32'd0);

        // LW 0x100 with two wait cycles
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("lw_stall0", 32'(stall), 32'd1);
        @(negedge clk);
        checkOutput("lw_req", 32'(dmem.req), 32'd1);
        checkOutput("lw_we", 32'(dmem.we), 32'd0);
        checkOutput("lw_addr", dmem.addr, 32'h100);
        checkOutput("lw_be", 32'(dmem.be), 32'hF);
        checkOutput("lw_stall1", 32'(stall), 32'd1);
        @(negedge clk);
        checkOutput("lw_stall2", 32'(stall), 32'd1);
        checkOutput("lw_req2", 32'(dmem.req), 32'd1);
        dmem.ack   = 1'b1;
        dmem.rdata = 32'hDEADBEEF;
        valid_in   = 1'b0;
        #1;
        checkOutput("lw_stall_ack", 32'(stall), 32'd0);
        @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput("lw_wbv", 32'(wb_valid), 32'd1);
        checkOutput("lw_rd", 32'(wb_rd), 32'd5);
        checkOutput("lw_data", wb_data, 32'hDEADBEEF);
        checkOutput("lw_req_done", 32'(dmem.req), 32'd0);
        @(negedge clk);
        checkOutput("lw_wbv_pulse", 32'(wb_valid), 32'd0);

        quickLoad("lb", LB, 32'h103, 5'd7, 32'h80FFFFFF, 32'hFFFFFF80);
        quickLoad("lbu", LBU, 32'h103, 5'd7, 32'h80FFFFFF, 32'h00000080);
        quickLoad("lh", LH, 32'h102, 5'd9, 32'h80011234, 32'hFFFF8001);

        // SH 0x102: upper halfword lanes, no writeback
        applyStimulus(SH, 32'h102, 5'd4, 32'h1234ABCD, 1'b0);
        @(negedge clk);
        checkOutput("sh_req", 32'(dmem.req), 32'd1);
        checkOutput("sh_we", 32'(dmem.we), 32'd1);
        checkOutput("sh_be", 32'(dmem.be), 32'hC);
        checkOutput("sh_wdata", dmem.wdata, 32'hABCDABCD);
        checkOutput("sh_addr", dmem.addr, 32'h100);
        dmem.ack = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput("sh_wbv", 32'(wb_valid), 32'd0);
        checkOutput("sh_req_done", 32'(dmem.req), 32'd0);

        applyStimulus(SB, 32'h101, 5'd4, 32'hCAFE0055, 1'b0);
        @(negedge clk);
        checkOutput("sb_be", 32'(dmem.be), 32'h2);
        checkOutput("sb_wdata", dmem.wdata, 32'h55555555);
        dmem.ack = 1'b1;
        valid_in = 1'b0;
        @(negedge clk);
        dmem.ack = 1'b0;

        // Misaligned LW and illegal load funct3 both fault without a request
        applyStimulus(LW, 32'h101, 5'd6, 32'h0, 1'b0);
        #1;
        checkOutput("mis_stall", 32'(stall), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("mis_req", 32'(dmem.req), 32'd0);
        checkOutput("mis_fault", 32'(mem_fault), 32'd1);
        checkOutput("mis_wbv", 32'(wb_valid), 32'd0);
        @(negedge clk);
        checkOutput("mis_fault_pulse", 32'(mem_fault), 32'd0);
        applyStimulus(LD3, 32'h100, 5'd6, 32'h0, 1'b0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("ill_fault", 32'(mem_fault), 32'd1);
        checkOutput("ill_req", 32'(dmem.req), 32'd0);

        // ALU writeback, then rd=0 suppression
        @(negedge clk);
        applyStimulus(ADD, 32'h7, 5'd3, 32'h0, 1'b1);
        #1;
        checkOutput("add_stall", 32'(stall), 32'd0);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("add_wbv", 32'(wb_valid), 32'd1);
        checkOutput("add_rd", 32'(wb_rd), 32'd3);
        checkOutput("add_data", wb_data, 32'h7);
        applyStimulus(ADD, 32'h7, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("add_rd0_wbv", 32'(wb_valid), 32'd0);

        // Stray ack in IDLE
        dmem.ack = 1'b1;
        dmem.rdata = 32'h12345678;
        @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput("idle_ack_wbv", 32'(wb_valid), 32'd0);
        checkOutput("idle_ack_req", 32'(dmem.req), 32'd0);

        // Reset during ACCESS aborts; the late ack must be ignored
        applyStimulus(LW, 32'h200, 5'd9, 32'h0, 1'b0);
        @(negedge clk);
        checkOutput("abort_req_before", 32'(dmem.req), 32'd1);
        reset = 1'b0;
        valid_in = 1'b0;
        #1;
        checkOutput("abort_stall", 32'(stall), 32'd0);
        @(negedge clk);
        checkOutput("abort_req", 32'(dmem.req), 32'd0);
        reset = 1'b1;
        dmem.ack = 1'b1;
        dmem.rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem.ack = 1'b0;
        checkOutput("abort_wbv", 32'(wb_valid), 32'd0);
        checkOutput("abort_req_after", 32'(dmem.req), 32'd0);
        applyStimulus(ADD, 32'h42, 5'd2, 32'h0, 1'b1);
        @(negedge clk);
        valid_in = 1'b0;
        checkOutput("abort_idle_wbv", 32'(wb_valid), 32'd1);
        checkOutput("abort_idle_data", wb_data, 32'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
